// File: rtl/mic_pkg.sv
// Shared definitions for the PDM microphone capture controller: state
// encodings, default sizing constants and a constant-evaluable clog2.
package mic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int CLK_DIV_DEF   = 50;
  localparam int DEC_DEF       = 128;
  localparam int N_SAMPLES_DEF = 1024;

  // Smallest r with 2**r >= value; used to size counters at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mic_clk_gen.sv
// Microphone clock divider. While run is high the counter counts down from
// CLK_DIV-1 and toggles the mic clock at zero, giving a 2*CLK_DIV period.
// strobe marks the cycle just before the mic clock falls, which is when the
// PDM bit is stable and gets sampled. With run low the divider sits at its
// reload value with the clock low, so the first rising edge lands exactly
// CLK_DIV cycles after run rises.
module mic_clk_gen
  import mic_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mic_clk,
  output logic strobe
);

  localparam int CW = clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          mclk_q, mclk_d;

  // Next divider count and mic clock level.
  always_comb begin
    div_d  = RELOAD;
    mclk_d = 1'b0;
    if (run) begin
      if (div_q == '0) begin
        div_d  = RELOAD;
        mclk_d = ~mclk_q;
      end else begin
        div_d  = div_q - 1'b1;
        mclk_d = mclk_q;
      end
    end
  end

  // Divider and mic clock registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      mclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      mclk_q <= mclk_d;
    end
  end

  // Gate with run so the pin drops in the very first idle cycle after an abort.
  assign mic_clk = mclk_q & run;
  assign strobe  = run & mclk_q & (div_q == '0);

endmodule

// File: rtl/mic_capture_ctrl.sv
// One-shot PDM microphone capture: runs the mic clock, throws away a warm-up
// interval, then counts ones over DEC-bit windows and writes each count to
// the sample RAM until N_SAMPLES have been stored or the capture is aborted.
module mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int WARMUP    = 16384,
  parameter int DEC       = DEC_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ADDR_W    = 10,
  parameter int PCM_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pdm_data,
  output logic              mic_clk,
  output logic              mic_lrsel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PCM_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt,
  output logic              led
);

  localparam int WARM_W = clog2(WARMUP + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [PCM_W-1:0]  BIT_LAST  = PCM_W'(DEC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(N_SAMPLES - 1);

  state_e              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [PCM_W-1:0]    acc_q, acc_d;
  logic [PCM_W-1:0]    bit_q, bit_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     smp_cnt_q, smp_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PCM_W-1:0]    wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                run;
  logic                strobe;
  logic [PCM_W-1:0]    window_sum;

  assign run        = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
  assign window_sum = acc_q + PCM_W'(pdm_data);

  mic_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .mic_clk (mic_clk),
    .strobe  (strobe)
  );

  // Sequencing, window accumulation and write generation.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    smp_cnt_d = smp_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stop has priority over a simultaneous start
        if (start && !stop) begin
          state_d   = ST_WARMUP;
          warm_d    = '0;
          acc_d     = '0;
          bit_d     = '0;
          idx_d     = '0;
          smp_cnt_d = '0;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (strobe) begin
          if (warm_q == WARM_LAST) begin
            state_d = ST_CAPTURE;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        // done_q is high in the cycle of the final write; leave one cycle
        // later so busy stays up alongside that write.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (done_q) begin
          state_d = ST_DONE;
        end else if (strobe) begin
          if (bit_q == BIT_LAST) begin
            wr_en_d   = 1'b1;
            wr_data_d = window_sum;
            wr_addr_d = idx_q;
            idx_d     = idx_q + 1'b1;
            smp_cnt_d = smp_cnt_q + 1'b1;
            acc_d     = '0;
            bit_d     = '0;
            if (idx_q == IDX_LAST) begin
              done_d = 1'b1;
            end
          end else begin
            acc_d = window_sum;
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered write/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      warm_q    <= '0;
      acc_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      smp_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      smp_cnt_q <= smp_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign mic_lrsel  = 1'b0;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign sample_cnt = smp_cnt_q;
  assign busy       = run;
  assign led        = run;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Bench for mic_capture_ctrl with a small configuration. Expected writes are
// queued when a capture is launched and popped as wr_en strobes appear.
module tb_mic_capture_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int WARMUP    = 4;
  localparam int DEC       = 8;
  localparam int N_SAMPLES = 4;
  localparam int ADDR_W    = 3;
  localparam int PCM_W     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pdm_data;
  logic              mic_clk;
  logic              mic_lrsel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PCM_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_cnt;
  logic              led;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PCM_W-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  pdm_mode = 0;   // 0: all zeros, 1: all ones, 2: alternating per mic clock

  mic_capture_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .WARMUP    (WARMUP),
    .DEC       (DEC),
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W),
    .PCM_W     (PCM_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pdm_data   (pdm_data),
    .mic_clk    (mic_clk),
    .mic_lrsel  (mic_lrsel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .led        (led)
  );

  always #5 clk = ~clk;

  // Microphone model: a new PDM bit after every falling edge of mic_clk.
  initial begin : pdm_model
    int   falls;
    logic prev;
    falls = 0;
    prev = 1'b0;
    pdm_data = 1'b0;
    forever begin
      @(negedge clk);
      if (prev && !mic_clk) falls++;
      prev = mic_clk;
      case (pdm_mode)
        0:       pdm_data = 1'b0;
        1:       pdm_data = 1'b1;
        default: pdm_data = falls[0];
      endcase
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic push_expected(input int n, input int data);
    wr_t t;
    for (int i = 0; i < n; i++) begin
      t.addr = ADDR_W'(i);
      t.data = PCM_W'(data);
      exp_q.push_back(t);
    end
  endtask

  // Leaves the caller at the negedge right after the edge that accepted start.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mic_clk, wr_en, done, led, mic_lrsel} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 000000", {busy, mic_clk, wr_en, done, led, mic_lrsel});
    end
    checks++;
    if ({sample_cnt, wr_addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_values got cnt=%0d addr=%0d data=%0d required 0", sample_cnt, wr_addr, wr_data);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mic_clk} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b mic_clk=%b required 0 0", busy, mic_clk);
    end
  endtask

  task automatic test_clock_and_ones();
    wr_t        e;
    logic [7:0] mv;
    int         first_wr, last_wr, nwr, done_c;
    bit         gap_ok;
    logic       busy_after, mic_after;
    first_wr = -1; last_wr = -1; nwr = 0; done_c = -1; gap_ok = 1'b1;
    busy_after = 1'b1; mic_after = 1'b1;
    pdm_mode = 1;
    push_expected(N_SAMPLES, DEC);
    start_pulse();
    checks++;
    if ({busy, led} !== 2'b11) begin
      errors++;
      $display("FAIL start_busy got busy=%b led=%b required 1 1", busy, led);
    end
    checks++;
    if (sample_cnt !== '0) begin
      errors++;
      $display("FAIL start_cnt got %0d required 0", sample_cnt);
    end
    mv = '0;
    mv[0] = mic_clk;
    for (int c = 1; c <= 220; c++) begin
      @(negedge clk);
      if (c < 8) mv[c] = mic_clk;
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ones_extra_write got addr=%0d data=%0d required none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
            errors++;
            $display("FAIL ones_write got addr=%0d data=%0d required addr=%0d data=%0d", wr_addr, wr_data, e.addr, e.data);
          end
        end
        if (nwr == 0) first_wr = c;
        else if (c - last_wr != 32) gap_ok = 1'b0;
        last_wr = c;
        nwr++;
      end
      if (done === 1'b1) done_c = c;
      if (done_c >= 0 && c == done_c + 1) begin
        busy_after = busy;
        mic_after = mic_clk;
      end
      if (done_c >= 0 && c == done_c + 2) break;
    end
    checks++;
    if (mv !== 8'b1100_1100) begin
      errors++;
      $display("FAIL mic_clk_wave got %b required 11001100", mv);
    end
    checks++;
    if (first_wr != 48) begin
      errors++;
      $display("FAIL first_write_cycle got %0d required 48", first_wr);
    end
    checks++;
    if (!gap_ok || nwr != 4) begin
      errors++;
      $display("FAIL write_spacing got writes=%0d gap_ok=%0d required 4 1", nwr, gap_ok);
    end
    checks++;
    if (done_c < 0 || done_c != last_wr) begin
      errors++;
      $display("FAIL done_with_last_write got done=%0d last_wr=%0d required equal", done_c, last_wr);
    end
    checks++;
    if ({busy_after, mic_after} !== 2'b00) begin
      errors++;
      $display("FAIL after_done got busy=%b mic_clk=%b required 0 0", busy_after, mic_after);
    end
    checks++;
    if (sample_cnt !== 4'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ones_final got cnt=%0d pending=%0d required 4 0", sample_cnt, exp_q.size());
    end
  endtask

  task automatic test_patterns();
    wr_t e;
    bit  seen;
    int  expv;
    for (int m = 0; m < 2; m++) begin
      pdm_mode = (m == 0) ? 2 : 0;
      expv = (m == 0) ? DEC / 2 : 0;
      push_expected(N_SAMPLES, expv);
      start_pulse();
      seen = 1'b0;
      for (int c = 1; c <= 220 && !seen; c++) begin
        @(negedge clk);
        if (wr_en === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pattern%0d_extra_write got addr=%0d data=%0d required none", m, wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
              errors++;
              $display("FAIL pattern%0d_write got addr=%0d data=%0d required addr=%0d data=%0d", m, wr_addr, wr_data, e.addr, e.data);
            end
          end
        end
        if (done === 1'b1) seen = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (!seen || exp_q.size() != 0 || sample_cnt !== 4'd4) begin
        errors++;
        $display("FAIL pattern%0d_final got done=%0d pending=%0d cnt=%0d required 1 0 4", m, seen, exp_q.size(), sample_cnt);
      end
    end
  endtask

  task automatic test_abort();
    wr_t  e;
    bit   done_seen, mic_seen;
    logic busy_a, mic_a;
    done_seen = 1'b0; mic_seen = 1'b0; busy_a = 1'b1; mic_a = 1'b1;
    pdm_mode = 1;
    push_expected(2, DEC);
    start_pulse();
    for (int c = 1; c <= 220; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL abort_extra_write got addr=%0d data=%0d required none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
            errors++;
            $display("FAIL abort_write got addr=%0d data=%0d required addr=%0d data=%0d", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (done === 1'b1) done_seen = 1'b1;
      if (c > 101 && mic_clk === 1'b1) mic_seen = 1'b1;
      // fifth strobe of the third window is at cycle 99
      if (c == 100) stop = 1'b1;
      if (c == 101) begin
        stop = 1'b0;
        busy_a = busy;
        mic_a = mic_clk;
      end
    end
    checks++;
    if ({busy_a, mic_a} !== 2'b00) begin
      errors++;
      $display("FAIL abort_stop got busy=%b mic_clk=%b required 0 0", busy_a, mic_a);
    end
    checks++;
    if (done_seen || mic_seen) begin
      errors++;
      $display("FAIL abort_quiet got done=%0d mic_clk_activity=%0d required 0 0", done_seen, mic_seen);
    end
    checks++;
    if (sample_cnt !== 4'd2 || wr_addr !== 3'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_count got cnt=%0d addr=%0d pending=%0d required 2 1 0", sample_cnt, wr_addr, exp_q.size());
    end
  endtask

  task automatic test_collisions();
    wr_t e;
    bit  busy_seen, seen;
    busy_seen = 1'b0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (busy !== 1'b0 || mic_clk !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (busy_seen || sample_cnt !== 4'd2) begin
      errors++;
      $display("FAIL start_stop_together got busy_seen=%0d cnt=%0d required 0 2", busy_seen, sample_cnt);
    end
    pdm_mode = 2;
    push_expected(N_SAMPLES, DEC / 2);
    start_pulse();
    for (int c = 1; c <= 220 && !seen; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL collide_extra_write got addr=%0d data=%0d required none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
            errors++;
            $display("FAIL collide_write got addr=%0d data=%0d required addr=%0d data=%0d", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (c == 60) start = 1'b1;
      if (c == 61) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!seen || exp_q.size() != 0 || sample_cnt !== 4'd4) begin
      errors++;
      $display("FAIL start_while_busy got done=%0d pending=%0d cnt=%0d required 1 0 4", seen, exp_q.size(), sample_cnt);
    end
  endtask

  task automatic test_reset_mid_capture();
    wr_t e;
    bit  seen;
    seen = 1'b0;
    pdm_mode = 1;
    push_expected(N_SAMPLES, DEC);
    start_pulse();
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        checks++;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
          errors++;
          $display("FAIL pre_reset_write got addr=%0d data=%0d required addr=%0d data=%0d", wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, mic_clk, wr_en, done, led} !== 5'b0 || {sample_cnt, wr_addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL async_reset got flags=%b cnt=%0d addr=%0d data=%0d required all 0",
               {busy, mic_clk, wr_en, done, led}, sample_cnt, wr_addr, wr_data);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_expected(N_SAMPLES, DEC);
    start_pulse();
    for (int c = 1; c <= 220 && !seen; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL restart_extra_write got addr=%0d data=%0d required none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
            errors++;
            $display("FAIL restart_write got addr=%0d data=%0d required addr=%0d data=%0d", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!seen || exp_q.size() != 0 || sample_cnt !== 4'd4) begin
      errors++;
      $display("FAIL restart_final got done=%0d pending=%0d cnt=%0d required 1 0 4", seen, exp_q.size(), sample_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clock_and_ones();
    test_patterns();
    test_abort();
    test_collisions();
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
Sequences one PDM microphone capture: generates the mic clock, discards a startup warm-up interval, then decimates the PDM bitstream into PCM samples by counting ones per window. It writes each sample into an external sample RAM, stops after N_SAMPLES or on abort, and reports status. It sits between the board microphone pins and the audio sample buffer, and is started and stopped by the user/control logic.

Parameters:
CLK_DIV, 50, system clocks per mic_clk half-period (100 MHz -> 1 MHz mic clock); must be >= 2
WARMUP, 16384, mic_clk periods discarded after start, before capture
DEC, 128, PDM bits per PCM sample (decimation window)
N_SAMPLES, 1024, samples per capture
ADDR_W, 10, width of wr_addr and sample_cnt; N_SAMPLES <= 2^ADDR_W
PCM_W, 8, width of wr_data; must equal clog2(DEC+1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a capture
stop  in  1  single-cycle abort request
pdm_data  in  1  microphone PDM data pin
mic_clk  out  1  microphone clock
mic_lrsel  out  1  channel select; tied 0
wr_en  out  1  one-cycle sample write strobe
wr_addr  out  ADDR_W  sample index for the write
wr_data  out  PCM_W  PCM sample (ones count)
busy  out  1  high in WARMUP and CAPTURE
done  out  1  one-cycle pulse when N_SAMPLES have been written
sample_cnt  out  ADDR_W+1  samples written in the current or last capture
led  out  1  mirrors busy

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset: all outputs 0, mic_clk 0, state IDLE, divider, accumulator and counters cleared.
- States:
  - IDLE -> WARMUP on start & !stop.
  - WARMUP -> CAPTURE after WARMUP strobes.
  - CAPTURE -> DONE after the N_SAMPLES-th write.
  - DONE -> IDLE after one cycle.
  - stop in WARMUP/CAPTURE -> IDLE on the next cycle.
- start while busy is ignored. start and stop together in IDLE: stop wins, block stays IDLE.
- Divider:
  - Active only in WARMUP/CAPTURE. Loaded with CLK_DIV-1 on entry to WARMUP, with mic_clk=0.
  - Decrements each clk. At 0 it toggles mic_clk and reloads.
  - mic_clk period is 2*CLK_DIV clocks. The first rising edge comes CLK_DIV cycles after WARMUP entry.
  - mic_clk runs without a gap across the WARMUP->CAPTURE transition.
  - mic_clk is forced to 0 in IDLE/DONE.
- Strobe: the cycle where the counter is 0 and mic_clk is 1 (the falling edge). pdm_data is sampled only on strobe cycles.
- WARMUP: counts strobes and ignores pdm_data.
- CAPTURE accumulation:
  - The accumulator adds pdm_data on each strobe.
  - On the DEC-th strobe of a window, the next cycle shows wr_en=1, wr_data=total ones including that bit (range 0..DEC), and wr_addr=current index.
  - The accumulator then restarts at 0, and the index and sample_cnt increment.
  - done pulses in the same cycle as the final wr_en. busy drops the cycle after.
- Abort: a partial window is discarded and never written. done is not asserted. sample_cnt holds the number of completed writes.
- sample_cnt clears to 0 on start. wr_addr holds its last value when idle.
- Reset mid-operation: asynchronous return to the reset values, with no trailing write.

Decomposition:
- Shared package mic_pkg holds:
  - state encodings IDLE/WARMUP/CAPTURE/DONE
  - a clog2 function
  - default constants for CLK_DIV, DEC and N_SAMPLES
- One sub-module, mic_clk_gen: inputs clk, reset, run; outputs mic_clk and strobe. It contains the divider and the falling-edge strobe.
- The FSM, accumulator and write logic stay in mic_capture_ctrl.

Test Plan:
Test parameters: CLK_DIV=2, WARMUP=4, DEC=8, N_SAMPLES=4, PCM_W=4.
- Clock timing: pulse start -> busy=1 next cycle; mic_clk rises 2 cycles after WARMUP entry with period 4; no wr_en during the first 4 strobes.
- Constant ones: pdm_data=1 -> 4 writes with wr_data=8 at wr_addr 0,1,2,3, spaced 32 clocks apart; done coincides with the 4th wr_en; busy=0 and mic_clk=0 afterwards; sample_cnt=4.
- Alternating input: pdm_data alternating per strobe -> every wr_data=4. pdm_data=0 -> every wr_data=0.
- Abort: stop 5 strobes into the third window -> no further wr_en, done never pulses, sample_cnt=2, mic_clk=0 next cycle.
- Request collisions: start and stop in the same IDLE cycle -> stays IDLE. start during CAPTURE -> ignored, addresses continue in sequence.
- Reset mid-capture: assert reset between clock edges -> all outputs 0 immediately. A new start afterwards writes again from wr_addr 0.
